// File: rtl/rc4_breaker_pkg.sv
// Shared types for the RC4 key-search result path.
// Message/key geometry, arbiter state encoding and a counter helper.
package rc4_breaker_pkg;

    localparam int MSG_LEN = 32;
    localparam int KEY_W   = 24;

    typedef logic [7:0]       msg_t [MSG_LEN];
    typedef logic [KEY_W-1:0] key_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ROM,
        LAUNCH,
        SEARCH,
        LATCH,
        FOUND,
        EXHAUSTED
    } arb_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/core_result_arbiter_if.sv
// Control and result bundle between the arbiter and the search cores.
// master = arbiter side, slave = cores / host side.
interface core_result_arbiter_if #(
    parameter int NUM_CORES = 4,
    parameter int MSG_LEN   = 32,
    parameter int KEY_W     = 24
);
    localparam int IDW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic                                  start;
    logic                                  read_rom_done;
    logic [NUM_CORES-1:0]                  core_done;
    logic [NUM_CORES-1:0]                  core_found;
    logic [NUM_CORES-1:0][KEY_W-1:0]       core_key;
    logic [NUM_CORES-1:0][MSG_LEN-1:0][7:0] core_data;

    logic                                  start_core;
    logic                                  stop_core;
    logic [IDW-1:0]                        winner_id;
    logic [KEY_W-1:0]                      result_key;
    logic [MSG_LEN-1:0][7:0]               result_data;
    logic [31:0]                           search_cycles;
    logic                                  busy;
    logic                                  done;
    logic                                  found;

    modport master (
        input  start, read_rom_done,
        input  core_done, core_found, core_key, core_data,
        output start_core, stop_core, winner_id,
        output result_key, result_data, search_cycles,
        output busy, done, found
    );

    modport slave (
        output start, read_rom_done,
        output core_done, core_found, core_key, core_data,
        input  start_core, stop_core, winner_id,
        input  result_key, result_data, search_cycles,
        input  busy, done, found
    );

endinterface

// File: rtl/lowest_index_encoder.sv
// Fixed-priority encoder: index of the lowest set bit plus any-set flag.
// Purely combinational.
module lowest_index_encoder #(
    parameter int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         valid
);

    // Scan downward so the lowest set index is the last write.
    always_comb begin
        idx   = '0;
        valid = |vec;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = W'(i);
        end
    end

endmodule

// File: rtl/core_result_arbiter.sv
// Launches the key-search cores, freezes them on the first hit and
// latches the winning key/plaintext; flags exhaustion otherwise.
module core_result_arbiter #(
    parameter int          NUM_CORES       = 4,
    parameter int          MSG_LEN         = 32,
    parameter int          KEY_W           = 24,
    parameter logic [31:0] SEARCH_CNT_INIT = 32'd0
) (
    input logic                  CLOCK_50,
    input logic                  reset,
    core_result_arbiter_if.master bus
);

    import rc4_breaker_pkg::*;

    localparam int IDW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    arb_state_t     state;
    logic [IDW-1:0] hit_idx;
    logic           hit;
    logic           all_done;

    lowest_index_encoder #(
        .N(NUM_CORES)
    ) u_enc (
        .vec   (bus.core_found),
        .idx   (hit_idx),
        .valid (hit)
    );

    assign all_done = &bus.core_done;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            bus.start_core    <= 1'b0;
            bus.stop_core     <= 1'b0;
            bus.winner_id     <= '0;
            bus.result_key    <= '0;
            bus.result_data   <= '0;
            bus.search_cycles <= '0;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            bus.found         <= 1'b0;
        end else begin
            bus.start_core <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= WAIT_ROM;
                        bus.busy <= 1'b1;
                    end
                end
                WAIT_ROM: begin
                    if (bus.read_rom_done) begin
                        state             <= LAUNCH;
                        bus.start_core    <= 1'b1;
                        bus.search_cycles <= SEARCH_CNT_INIT;
                    end
                end
                LAUNCH: begin
                    state <= SEARCH;
                end
                SEARCH: begin
                    bus.search_cycles <= sat_inc(bus.search_cycles);
                    // A hit outranks all-done seen on the same edge.
                    if (hit) begin
                        state           <= LATCH;
                        bus.stop_core   <= 1'b1;
                        bus.winner_id   <= hit_idx;
                        bus.result_key  <= bus.core_key[hit_idx];
                        bus.result_data <= bus.core_data[hit_idx];
                    end else if (all_done) begin
                        state         <= EXHAUSTED;
                        bus.stop_core <= 1'b1;
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                    end
                end
                LATCH: begin
                    state     <= FOUND;
                    bus.busy  <= 1'b0;
                    bus.done  <= 1'b1;
                    bus.found <= 1'b1;
                end
                FOUND, EXHAUSTED: begin
                    state <= state;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
